sync_debounce_fsmd: RTL

//  Conditions one raw mechanical switch/button for the counter and display test

---
 rtl/sync_debounce_fsmd.sv | 96 +++++++++
 1 files changed

// File: rtl/sync_debounce_fsmd.sv
// Switch conditioner: two-flop synchronizer feeding a four-state debounce FSMD.
// Emits a debounced level and registered one-cycle press/release ticks.
`timescale 1ns/1ps
module sync_debounce_fsmd #(
  parameter int N = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic db_tick,
  output logic rel_tick
);

  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

  localparam logic [N-1:0] Q_LOAD = '1;
  localparam logic [N-1:0] Q_ONE  = {{(N-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic [N-1:0]   q_q, q_d;
  logic           s1_q, s2_q;
  logic           db_tick_q, db_tick_d;
  logic           rel_tick_q, rel_tick_d;
  logic           sw_s;
  logic           q_zero;

  assign sw_s   = s2_q;
  assign q_zero = (q_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      state_q    <= ZERO;
      q_q        <= '0;
      db_tick_q  <= 1'b0;
      rel_tick_q <= 1'b0;
    end else begin
      s1_q       <= sw;
      s2_q       <= s1_q;
      state_q    <= state_d;
      q_q        <= q_d;
      db_tick_q  <= db_tick_d;
      rel_tick_q <= rel_tick_d;
    end
  end

  // A reversal in either wait state abandons the count; the next attempt reloads.
  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    db_tick_d  = 1'b0;
    rel_tick_d = 1'b0;
    case (state_q)
      ZERO: begin
        if (sw_s) begin
          q_d     = Q_LOAD;
          state_d = WAIT1;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_d = ZERO;
        end else if (!q_zero) begin
          q_d = q_q - Q_ONE;
        end else begin
          state_d   = ONE;
          db_tick_d = 1'b1;
        end
      end
      ONE: begin
        if (!sw_s) begin
          q_d     = Q_LOAD;
          state_d = WAIT0;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          state_d = ONE;
        end else if (!q_zero) begin
          q_d = q_q - Q_ONE;
        end else begin
          state_d    = ZERO;
          rel_tick_d = 1'b1;
        end
      end
      default: state_d = ZERO;
    endcase
  end

  assign db_level = (state_q == ONE) || (state_q == WAIT0);
  assign db_tick  = db_tick_q;
  assign rel_tick = rel_tick_q;

endmodule
